mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and load-data aligner; drives the register file write port (regwrite, write_reg, write_data).
- Captures memory-stage results each cycle, performs byte/half extraction with sign/zero extension, and selects ALU result or load data.
- Registered outputs double as the WB-stage forwarding source for the hazard unit.

Parameters:
- DATA_W, 32, datapath width; only 32 supported.
- REG_ADDR_W, 5, register index width.
- CNT_W, 32, retire counter width; used only with the optional feature.

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous active-low reset (asserted when 0)
- stall  input  1  hold all stage registers
- flush  input  1  load a bubble on the next edge
- in_valid  input  1  MEM stage holds a real instruction
- in_regwrite  input  1  instruction writes a GPR
- in_memtoreg  input  1  1 = load data, 0 = ALU result
- in_load_type  input  3  load kind (see package constants)
- in_byte_off  input  2  address[1:0] of the load
- in_write_reg  input  REG_ADDR_W  destination register
- in_alu_result  input  DATA_W  ALU result or effective address
- in_mem_rdata  input  DATA_W  raw little-endian word from data memory
- wb_valid  output  1  WB stage holds a real instruction
- regwrite  output  1  register file write enable
- write_reg  output  REG_ADDR_W  register file write index
- write_data  output  DATA_W  register file write data
- misalign  output  1  registered 1-cycle flag: the WB load was misaligned

Behaviour:
- Reset (reset=0, asynchronous): all outputs and internal flops go to 0 immediately; the stage holds a bubble until the first edge after release.
- Latency: exactly 1 cycle; all outputs come straight from flops, with no combinational path from inputs to outputs.
- Per rising edge, evaluated in priority order:
  - flush: capture a bubble (wb_valid=0, regwrite=0, write_reg=0, write_data=0, misalign=0). Flush wins over stall.
  - stall: hold every register. A stalled instruction keeps regwrite asserted, so a repeated identical write is harmless.
  - otherwise: capture the new values.
- Captured regwrite = in_valid & in_regwrite & (in_write_reg != 0). Writes to x0 are suppressed here.
- Captured write_data = in_memtoreg ? aligned load : in_alu_result.
- Load types, little-endian, byte k = rdata[8k+7:8k]:
  - LW=0: full word; byte_off is ignored for data selection.
  - LH=1: half selected by byte_off[1], sign-extended.
  - LHU=2: same half selection, zero-extended.
  - LB=3: byte selected by byte_off, sign-extended.
  - LBU=4: same byte selection, zero-extended.
  - Codes 5-7 are treated as LW.
- Captured misalign = in_valid & in_memtoreg & ((LW & off!=0) | ((LH|LHU) & off[0])). Data is still written as defined above; trapping is handled elsewhere.
- in_load_type and in_byte_off are ignored when in_memtoreg=0.
- Reset deassertion mid-operation: the first captured instruction is the one presented at the first rising edge after reset=1.

Optional Feature:
- Macro: MEM_WB_RETIRE_CNT_EN.
- Defined:
  - Adds output port retire_cnt (CNT_W bits).
  - Increments on every edge that captures in_valid=1 with stall=0 and flush=0.
  - Wraps from all-ones to 0.
  - Cleared by reset.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - Load-type constants LD_LW=3'd0, LD_LH=3'd1, LD_LHU=3'd2, LD_LB=3'd3, LD_LBU=3'd4.
  - DATA_W and REG_ADDR_W defaults.
- One combinational sub-module, load_align (inputs: rdata, load_type, byte_off; outputs: aligned data, misalign), instantiated on the input side of the flops.

Test Plan:
- Reset: drive reset=0 mid-run with regwrite=1 held → all outputs are 0 with no clock edge required; after release and one edge with in_valid=1, in_regwrite=1, reg=5, alu=0x1234, memtoreg=0 → write_reg=5, write_data=0x00001234, regwrite=1.
- Load extraction, all with rdata=0x80F1A27F:
  - LB off=0 → 0x0000007F
  - LB off=3 → 0xFFFFFF80
  - LBU off=3 → 0x00000080
  - LH off=2 → 0xFFFF80F1
  - LHU off=0 → 0x0000A27F
  - LW off=0 → 0x80F1A27F, misalign=0
- Misalign: LW off=1 → misalign=1 for exactly one cycle and write_data=0x80F1A27F; LH off=1 → misalign=1; LB off=1 → misalign=0.
- x0 suppression: in_regwrite=1, in_write_reg=0, in_valid=1 → regwrite=0, wb_valid=1.
- Stall/flush:
  - Capture reg=7, then stall for 3 cycles while inputs change → outputs stay at reg=7.
  - Assert stall=1 and flush=1 together → next edge produces a bubble (wb_valid=0, regwrite=0).
- MEM_WB_RETIRE_CNT_EN: 10 valid cycles, 2 stalled cycles and 1 flushed cycle → retire_cnt=10; preload near all-ones → counter wraps to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants.
// Load-type codes, datapath widths, MEM/WB bundle.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LHU = 3'd2;
  localparam logic [2:0] LD_LB  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0]     write_data;
    logic                  misalign;
  } mem_wb_t;

endpackage

// File: rtl/load_align.sv
// Little-endian byte/half extraction for loads.
// Pure combinational; misalign is ungated here.
module load_align
  import mips_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [2:0]        load_type,
  input  logic [1:0]        byte_off,
  output logic [DATA_W-1:0] data,
  output logic              misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_h;
  logic        is_hu;
  logic        is_b;
  logic        is_bu;

  assign byte_sel = 8'(rdata >> {byte_off, 3'b000});
  assign half_sel = byte_off[1] ? rdata[31:16]
                                : rdata[15:0];

  assign is_h  = (load_type == LD_LH);
  assign is_hu = (load_type == LD_LHU);
  assign is_b  = (load_type == LD_LB);
  assign is_bu = (load_type == LD_LBU);

  // select and extend; unknown codes act as LW
  always_comb begin
    data     = rdata;
    misalign = (byte_off != 2'b00);
    unique case (1'b1)
      is_h: begin
        data     = {{16{half_sel[15]}}, half_sel};
        misalign = byte_off[0];
      end
      is_hu: begin
        data     = {16'h0, half_sel};
        misalign = byte_off[0];
      end
      is_b: begin
        data     = {{24{byte_sel[7]}}, byte_sel};
        misalign = 1'b0;
      end
      is_bu: begin
        data     = {24'h0, byte_sel};
        misalign = 1'b0;
      end
      default: begin
        data     = rdata;
        misalign = (byte_off != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load aligner.
// Optional retire counter: MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = mips_pkg::DATA_W,
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  in_regwrite,
  input  logic                  in_memtoreg,
  input  logic [2:0]            in_load_type,
  input  logic [1:0]            in_byte_off,
  input  logic [REG_ADDR_W-1:0] in_write_reg,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_mem_rdata,
`ifdef MEM_WB_RETIRE_CNT_EN
  output logic [CNT_W-1:0]      retire_cnt,
`endif
  output logic                  wb_valid,
  output logic                  regwrite,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0]     write_data,
  output logic                  misalign
);

  mem_wb_t             d;
  mem_wb_t             q;
  logic [DATA_W-1:0]   ld_data;
  logic                ld_mis;

  load_align u_align (
    .rdata     (in_mem_rdata),
    .load_type (in_load_type),
    .byte_off  (in_byte_off),
    .data      (ld_data),
    .misalign  (ld_mis)
  );

  assign d.valid      = in_valid;
  assign d.regwrite   = in_valid & in_regwrite
                      & (in_write_reg != '0);
  assign d.write_reg  = in_write_reg;
  assign d.write_data = in_memtoreg ? ld_data
                                    : in_alu_result;
  assign d.misalign   = in_valid & in_memtoreg
                      & ld_mis;

  // stage register: flush beats stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      q <= '0;
    else if (flush)
      q <= '0;
    else if (!stall)
      q <= d;
  end

  assign wb_valid   = q.valid;
  assign regwrite   = q.regwrite;
  assign write_reg  = q.write_reg;
  assign write_data = q.write_data;
  assign misalign   = q.misalign;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // count instructions entering WB
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else if (!flush && !stall && in_valid)
      cnt_q <= cnt_q + 1'b1;
  end

  assign retire_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage.
// Checks reset, loads, misalign, x0, stall/flush.
module tb_mem_wb_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic        in_regwrite;
  logic        in_memtoreg;
  logic [2:0]  in_load_type;
  logic [1:0]  in_byte_off;
  logic [4:0]  in_write_reg;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_rdata;
  logic        wb_valid;
  logic        regwrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        misalign;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_regwrite   (in_regwrite),
    .in_memtoreg   (in_memtoreg),
    .in_load_type  (in_load_type),
    .in_byte_off   (in_byte_off),
    .in_write_reg  (in_write_reg),
    .in_alu_result (in_alu_result),
    .in_mem_rdata  (in_mem_rdata),
`ifdef MEM_WB_RETIRE_CNT_EN
    .retire_cnt    (retire_cnt),
`endif
    .wb_valid      (wb_valid),
    .regwrite      (regwrite),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .misalign      (misalign)
  );

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ld(logic [2:0] t,
                    logic [1:0] off);
    in_valid     = 1'b1;
    in_regwrite  = 1'b1;
    in_memtoreg  = 1'b1;
    in_write_reg = 5'd3;
    in_load_type = t;
    in_byte_off  = off;
    in_mem_rdata = 32'h80F1A27F;
    cyc();
  endtask

  initial begin
    reset         = 1'b0;
    stall         = 1'b0;
    flush         = 1'b0;
    in_valid      = 1'b0;
    in_regwrite   = 1'b0;
    in_memtoreg   = 1'b0;
    in_load_type  = LD_LW;
    in_byte_off   = 2'd0;
    in_write_reg  = 5'd0;
    in_alu_result = 32'h0;
    in_mem_rdata  = 32'h0;
    cyc();
    reset = 1'b1;

    // get a live write into WB, then async reset
    in_valid      = 1'b1;
    in_regwrite   = 1'b1;
    in_write_reg  = 5'd9;
    in_alu_result = 32'hDEAD;
    cyc();
    chk("pre_rst_rw", 32'(regwrite), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_valid", 32'(wb_valid), 32'd0);
    chk("rst_rw", 32'(regwrite), 32'd0);
    chk("rst_reg", 32'(write_reg), 32'd0);
    chk("rst_data", write_data, 32'd0);
    chk("rst_mis", 32'(misalign), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    in_write_reg  = 5'd5;
    in_alu_result = 32'h1234;
    cyc();
    chk("post_reg", 32'(write_reg), 32'd5);
    chk("post_data", write_data, 32'h1234);
    chk("post_rw", 32'(regwrite), 32'd1);

    ld(LD_LB, 2'd0);
    chk("lb0", write_data, 32'h0000007F);
    ld(LD_LB, 2'd3);
    chk("lb3", write_data, 32'hFFFFFF80);
    ld(LD_LBU, 2'd3);
    chk("lbu3", write_data, 32'h00000080);
    ld(LD_LH, 2'd2);
    chk("lh2", write_data, 32'hFFFF80F1);
    ld(LD_LHU, 2'd0);
    chk("lhu0", write_data, 32'h0000A27F);
    ld(LD_LW, 2'd0);
    chk("lw0", write_data, 32'h80F1A27F);
    chk("lw0_mis", 32'(misalign), 32'd0);
    ld(3'd6, 2'd0);
    chk("ld6", write_data, 32'h80F1A27F);

    ld(LD_LW, 2'd1);
    chk("lw1_mis", 32'(misalign), 32'd1);
    chk("lw1", write_data, 32'h80F1A27F);
    ld(LD_LB, 2'd1);
    chk("lb1_mis", 32'(misalign), 32'd0);
    chk("lb1", write_data, 32'hFFFFFFA2);
    ld(LD_LH, 2'd1);
    chk("lh1_mis", 32'(misalign), 32'd1);
    chk("lh1", write_data, 32'hFFFFA27F);

    // alu path ignores load fields
    in_memtoreg   = 1'b0;
    in_load_type  = LD_LW;
    in_byte_off   = 2'd1;
    in_write_reg  = 5'd0;
    in_alu_result = 32'h55;
    cyc();
    chk("x0_rw", 32'(regwrite), 32'd0);
    chk("x0_valid", 32'(wb_valid), 32'd1);
    chk("alu_mis", 32'(misalign), 32'd0);
    chk("alu_data", write_data, 32'h55);

    in_write_reg  = 5'd7;
    in_alu_result = 32'h77;
    cyc();
    chk("cap7", 32'(write_reg), 32'd7);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_write_reg  = 5'(9 + i);
      in_alu_result = 32'h99 + 32'(i);
      cyc();
      chk("stall_reg", 32'(write_reg), 32'd7);
      chk("stall_data", write_data, 32'h77);
      chk("stall_rw", 32'(regwrite), 32'd1);
    end
    flush = 1'b1;
    cyc();
    chk("fl_valid", 32'(wb_valid), 32'd0);
    chk("fl_rw", 32'(regwrite), 32'd0);
    chk("fl_reg", 32'(write_reg), 32'd0);
    chk("fl_data", write_data, 32'd0);
    stall = 1'b0;
    flush = 1'b0;

`ifdef MEM_WB_RETIRE_CNT_EN
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    stall = 1'b1;
    cyc();
    cyc();
    stall = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("retire", retire_cnt, 32'd10);
`endif

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
